// File: rtl/crush_param_sched_if.sv
// Pot / audio bus between the ADC scanner, the audio path and the crush scheduler.
// master drives pot and sample strobes; slave is the scheduler.
interface crush_param_sched_if;
    logic        [9:0]  pot_raw;
    logic               pot_raw_valid;
    logic signed [15:0] sample_in;
    logic               sample_in_valid;
    logic        [9:0]  pot_crush;
    logic               pot_crush_update;
    logic               busy;

    modport master (
        output pot_raw, pot_raw_valid, sample_in, sample_in_valid,
        input  pot_crush, pot_crush_update, busy
    );

    modport slave (
        input  pot_raw, pot_raw_valid, sample_in, sample_in_valid,
        output pot_crush, pot_crush_update, busy
    );
endinterface

// File: rtl/crush_param_sched.sv
// Crush pot scheduler: hysteresis, zero-crossing deferred apply, dwell.
// Optional CRUSH_SCHED_SLEW_EN limits each apply step to 32 LSB.
module crush_param_sched #(
    parameter int TIMEOUT_SAMPLES = 480,
    parameter int HYST            = 8,
    parameter int DWELL_SAMPLES   = 64
) (
    input logic               clk,
    input logic               rst_n,
    crush_param_sched_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int DW = $clog2(DWELL_SAMPLES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY, DWELL} state_t;

    state_t        state_q, state_d;
    logic [9:0]    crush_q, crush_d;
    logic [9:0]    target_q, target_d;
    logic          upd_q, upd_d;
    logic          pend_q, pend_d;
    logic          sign_q, sign_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    logic [10:0] raw_ext, cur_ext, delta;
    logic        req, zc, tmo, dend, more;
    logic [9:0]  apply_val;

    always_comb begin
        raw_ext = {1'b0, bus.pot_raw};
        cur_ext = {1'b0, crush_q};
        delta   = (raw_ext >= cur_ext) ? raw_ext - cur_ext
                                       : cur_ext - raw_ext;
        req  = bus.pot_raw_valid && (delta > 11'(HYST));
        zc   = bus.sample_in_valid &&
               ((bus.sample_in[15] != sign_q) || (bus.sample_in == 16'sd0));
        tmo  = (tcnt_q == TW'(TIMEOUT_SAMPLES - 1));
        dend = (dcnt_q == DW'(DWELL_SAMPLES - 1));
    end

`ifdef CRUSH_SCHED_SLEW_EN
    logic [9:0] gap, step;
    logic       up;

    always_comb begin
        up        = (target_q >= crush_q);
        gap       = up ? target_q - crush_q : crush_q - target_q;
        step      = (gap > 10'd32) ? 10'd32 : gap;
        apply_val = up ? crush_q + step : crush_q - step;
    end
`else
    always_comb begin
        apply_val = target_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        crush_d  = crush_q;
        target_d = target_q;
        upd_d    = 1'b0;
        pend_d   = pend_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        sign_d   = bus.sample_in_valid ? bus.sample_in[15] : sign_q;
        more     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    target_d = bus.pot_raw;
                    tcnt_d   = '0;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (req) target_d = bus.pot_raw;
                if (bus.sample_in_valid) begin
                    if (zc || tmo) state_d = APPLY;
                    else           tcnt_d  = tcnt_q + 1'b1;
                end
            end
            APPLY: begin
                crush_d = apply_val;
                dcnt_d  = '0;
                upd_d   = 1'b1;
                state_d = DWELL;
            end
            DWELL: begin
                if (req) begin
                    pend_d   = 1'b1;
                    target_d = bus.pot_raw;
                end
`ifdef CRUSH_SCHED_SLEW_EN
                // Unfinished slew keeps the sequence stepping.
                more = (target_d != crush_q);
`endif
                if (bus.sample_in_valid) begin
                    if (dend) begin
                        if (pend_q || req || more) begin
                            state_d = ARMED;
                            tcnt_d  = '0;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            crush_q  <= '0;
            target_q <= '0;
            upd_q    <= 1'b0;
            pend_q   <= 1'b0;
            sign_q   <= 1'b0;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            crush_q  <= crush_d;
            target_q <= target_d;
            upd_q    <= upd_d;
            pend_q   <= pend_d;
            sign_q   <= sign_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign bus.pot_crush        = crush_q;
    assign bus.pot_crush_update = upd_q;
    assign bus.busy             = (state_q != IDLE);
endmodule

// File: doc/crush_param_sched.md
Name: crush_param_sched

Overview:
- Configuration controller that sits between the pot ADC scanner and the bit-crush/downsample stage.
- Filters raw pot readings with hysteresis.
- Defers each crush-setting change to a zero crossing of the audio stream, with a timeout fallback, so that gain, mask and hold-rate jumps do not click.
- Enforces a minimum dwell between successive changes.

Parameters:
- TIMEOUT_SAMPLES, 480: max samples to wait for a zero crossing before forcing the update (10 ms at 48 kHz); must be >= 1.
- HYST, 8: minimum |pot_raw - pot_crush| (LSBs) that counts as a change request.
- DWELL_SAMPLES, 64: samples to hold a newly applied value before another change may be armed; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pot_raw  in  10  raw crush pot reading
- pot_raw_valid  in  1  one-cycle strobe, pot_raw is new
- sample_in  in  16  signed audio sample feeding the crush stage
- sample_in_valid  in  1  one-cycle strobe per audio sample
- pot_crush  out  10  registered setting driven to the crush stage
- pot_crush_update  out  1  one-cycle pulse in the cycle after pot_crush changes
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. On reset assertion, immediately:
  - state = IDLE; pot_crush = 0; pot_crush_update = 0; busy = 0
  - target = 0; pending = 0; prev_sign = 0; all counters = 0
- Reset mid-operation discards any armed or pending change.
- Change test: delta = |pot_raw - pot_crush|, computed as an 11-bit unsigned absolute difference. A request exists when pot_raw_valid = 1 and delta > HYST; delta == HYST is not a request.
- Zero crossing: on sample_in_valid, zc = (sample_in[15] != prev_sign) or (sample_in == 0). prev_sign <= sample_in[15] on every sample_in_valid, in all states.
- FSM states: IDLE, ARMED, APPLY, DWELL.
  - IDLE:
    - On request: target <= pot_raw; tcnt <= 0; go to ARMED.
    - A zc in the same cycle is not consumed.
  - ARMED:
    - A further request overwrites target and does not restart tcnt.
    - A pot_raw_valid with delta <= HYST leaves target unchanged.
    - On sample_in_valid with zc: go to APPLY.
    - Otherwise on sample_in_valid: if tcnt == TIMEOUT_SAMPLES-1, go to APPLY; else tcnt++.
    - If zc and timeout coincide, APPLY is entered once.
  - APPLY (exactly one cycle):
    - pot_crush <= target; dcnt <= 0; go to DWELL.
    - pot_crush_update = 1 in the following cycle.
  - DWELL:
    - On each sample_in_valid: if dcnt == DWELL_SAMPLES-1, leave; else dcnt++.
    - A request during DWELL sets pending = 1 and target <= pot_raw. The delta is measured against the new pot_crush.
    - Exit: if pending, go to ARMED with tcnt <= 0 and pending <= 0; else go to IDLE.
- Latency:
  - Request to APPLY: at most TIMEOUT_SAMPLES sample strobes, plus 1 cycle.
  - pot_crush changes on the clock edge that leaves APPLY.
- pot_crush is never written outside APPLY, so it is stable between update pulses.
- If pot_raw_valid and sample_in_valid coincide, the target update and the crossing evaluation both happen in that cycle.

Optional Feature:
- Macro: CRUSH_SCHED_SLEW_EN.
- Defined:
  - APPLY moves pot_crush toward target by at most 32 LSB, i.e. one pot_crush[9:5] code: pot_crush +/- min(32, |target - pot_crush|).
  - If target is still not reached after DWELL, pending is forced to 1 and the sequence re-enters ARMED.
  - A full-scale 0->1023 sweep therefore takes 32 APPLY steps.
- Undefined: APPLY jumps directly to target; slew logic is absent.

Test Plan:
1. Hysteresis gate:
   - Reset; pot_raw = 8 valid -> stays IDLE, busy = 0, no update.
   - pot_raw = 9 valid -> ARMED, busy = 1.
2. Zero-crossing apply:
   - From rest, pot_raw = 640 valid; samples +100, +50, -20 -> update pulse one cycle after APPLY, which follows the -20 strobe.
   - pot_crush = 640; then DWELL.
3. Timeout:
   - TIMEOUT_SAMPLES = 4; pot_raw = 300 valid; samples all +1000.
   - The 4th strobe forces APPLY; pot_crush = 300.
4. Retarget while armed:
   - pot_raw = 200, then after 2 positive samples pot_raw = 900; crossing on sample 3.
   - pot_crush = 900; timeout counted from the first request.
5. Pending in dwell:
   - DWELL_SAMPLES = 64; during DWELL pot_raw = 100 valid.
   - After the 64th strobe -> ARMED (not IDLE); next crossing gives pot_crush = 100.
6. Async reset mid-ARMED:
   - Drop rst_n between clock edges -> pot_crush = 0, busy = 0 immediately.
   - After release, a crossing sample produces no update.
   - With CRUSH_SCHED_SLEW_EN: 0 -> 1023 request gives pot_crush 32, 64, ... reaching 1023 in 32 updates.
